data_mem_ctrl: RTL and testbench

Parametrised, handshaked data memory for the pipelined RISC-V core's MEM stage. It serves all RV32I loads and stores (LB/LH/LW/LBU/LHU/SB/SH/SW) from a byte-addressable, word-banked array. Depth and wait states are configurable, and a request/response protocol lets the pipeline stall on slow or split accesses. Range and encoding errors are flagged instead of silently corrupting state.

---
 rtl/data_mem_ctrl_if.sv | 22 ++
 rtl/data_mem_ctrl.sv | 158 +++++++++++++++
 tb/tb_data_mem_ctrl.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/data_mem_ctrl_if.sv
// Request/response bus between the MEM pipeline stage (master) and data_mem_ctrl (slave).
interface data_mem_ctrl_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [2:0]  req_func3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    modport master (
        output req_valid, req_write, req_func3, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_write, req_func3, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/data_mem_ctrl.sv
// RV32I data memory with wait states and request/response handshake.
// Optional MISALIGN_SPLIT_EN: misaligned in-range accesses become two word accesses instead of errors.
module data_mem_ctrl #(
    parameter int DEPTH_WORDS = 64,
    parameter int WAIT_CYCLES = 0
) (
    input  logic            clk,
    input  logic            rst,
    data_mem_ctrl_if.slave  bus
);
    // state | meaning
    // IDLE  | ready for a request
    // WAIT  | inserting WAIT_CYCLES stall cycles
    // ACC0  | access word addr[31:2]
    // ACC1  | access word addr[31:2]+1 (split only)
    // RESP  | one-cycle response
    typedef enum logic [2:0] {S_IDLE, S_WAIT, S_ACC0, S_ACC1, S_RESP} state_t;

    localparam int          AW         = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [32:0] BYTE_LIMIT = 33'(4 * DEPTH_WORDS);

    state_t      r_state, w_state_nxt;
    logic        r_write;
    logic [2:0]  r_func3;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [3:0]  r_wait_cnt;
    logic [31:0] r_ldata;
    logic [31:0] r_rsp_rdata;
    logic        r_rsp_err;
    logic [31:0] r_mem [DEPTH_WORDS];

    logic [2:0]  w_nbytes;
    logic        w_enc_err, w_misalign, w_range_err, w_err, w_split;
    logic [32:0] w_last_byte;
    logic        w_phase1, w_acc;
    logic [AW-1:0] w_word_idx;
    logic [31:0] w_rd_word, w_ldata_nxt;
    logic [3:0]  w_lane_en;
    logic [1:0]  w_lane_src [4];
    logic [7:0]  w_wbyte [4];

    function automatic logic [31:0] f_extend(input logic [2:0] f3, input logic [31:0] d);
        case (f3)
            3'b000:  return {{24{d[7]}}, d[7:0]};
            3'b001:  return {{16{d[15]}}, d[15:0]};
            3'b100:  return {24'd0, d[7:0]};
            3'b101:  return {16'd0, d[15:0]};
            default: return d;
        endcase
    endfunction

    always_comb begin
        w_nbytes  = 3'd4;
        w_enc_err = 1'b0;
        case (r_func3)
            3'b000:  w_nbytes = 3'd1;
            3'b001:  w_nbytes = 3'd2;
            3'b010:  w_nbytes = 3'd4;
            3'b100:  begin w_nbytes = 3'd1; w_enc_err = r_write; end
            3'b101:  begin w_nbytes = 3'd2; w_enc_err = r_write; end
            default: w_enc_err = 1'b1;
        endcase
    end

    assign w_misalign  = ((w_nbytes == 3'd2) && (r_addr[1:0] == 2'b11)) ||
                         ((w_nbytes == 3'd4) && (r_addr[1:0] != 2'b00));
    // Highest byte touched covers both words of a split access.
    assign w_last_byte = {1'b0, r_addr} + {30'd0, w_nbytes} - 33'd1;
    assign w_range_err = (w_last_byte >= BYTE_LIMIT);

`ifdef MISALIGN_SPLIT_EN
    assign w_err   = w_enc_err | w_range_err;
    assign w_split = w_misalign & ~w_err;
`else
    assign w_err   = w_enc_err | w_range_err | w_misalign;
    assign w_split = 1'b0;
`endif

    assign w_phase1   = (r_state == S_ACC1);
    assign w_acc      = ((r_state == S_ACC0) || (r_state == S_ACC1)) && !w_err;
    assign w_word_idx = r_addr[AW+1:2] + AW'(w_phase1);
    assign w_rd_word  = r_mem[w_word_idx];

    // Map each lane of the current word to the request byte it carries.
    always_comb begin
        int off;
        int k;
        off         = int'(r_addr[1:0]);
        w_lane_en   = 4'b0000;
        w_ldata_nxt = r_ldata;
        for (int l = 0; l < 4; l++) begin
            k             = w_phase1 ? (4 - off + l) : (l - off);
            w_lane_src[l] = 2'(k);
            w_lane_en[l]  = w_acc && (w_phase1 || (l >= off)) && (k < int'(w_nbytes));
            w_wbyte[l]    = r_wdata[{w_lane_src[l], 3'b000} +: 8];
            if (w_lane_en[l] && !r_write)
                w_ldata_nxt[{w_lane_src[l], 3'b000} +: 8] = w_rd_word[l*8 +: 8];
        end
    end

    always_ff @(posedge clk) begin
        if (w_acc && r_write) begin
            for (int l = 0; l < 4; l++)
                if (w_lane_en[l])
                    r_mem[w_word_idx][l*8 +: 8] <= w_wbyte[l];
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: if (bus.req_valid) w_state_nxt = (WAIT_CYCLES != 0) ? S_WAIT : S_ACC0;
            S_WAIT: if (r_wait_cnt == 4'd1) w_state_nxt = S_ACC0;
            S_ACC0: w_state_nxt = w_split ? S_ACC1 : S_RESP;
            S_ACC1: w_state_nxt = S_RESP;
            S_RESP: w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_write     <= 1'b0;
            r_func3     <= 3'd0;
            r_addr      <= 32'd0;
            r_wdata     <= 32'd0;
            r_wait_cnt  <= 4'd0;
            r_ldata     <= 32'd0;
            r_rsp_rdata <= 32'd0;
            r_rsp_err   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if ((r_state == S_IDLE) && bus.req_valid) begin
                r_write    <= bus.req_write;
                r_func3    <= bus.req_func3;
                r_addr     <= bus.req_addr;
                r_wdata    <= bus.req_wdata;
                r_wait_cnt <= 4'(WAIT_CYCLES);
                r_ldata    <= 32'd0;
            end
            if (r_state == S_WAIT)
                r_wait_cnt <= r_wait_cnt - 4'd1;
            if (w_acc)
                r_ldata <= w_ldata_nxt;
            if ((w_state_nxt == S_RESP) && (r_state != S_RESP)) begin
                r_rsp_err   <= w_err;
                r_rsp_rdata <= (w_err || r_write) ? 32'd0 : f_extend(r_func3, w_ldata_nxt);
            end
        end
    end

    assign bus.req_ready = (r_state == S_IDLE);
    assign bus.rsp_valid = (r_state == S_RESP);
    assign bus.rsp_rdata = r_rsp_rdata;
    assign bus.rsp_err   = r_rsp_err;
endmodule

// File: tb/tb_data_mem_ctrl.sv
// Directed bench for data_mem_ctrl: WAIT_CYCLES=0 and WAIT_CYCLES=3 instances sharing clk/rst.
module tb_data_mem_ctrl;
    localparam logic [2:0] F_B = 3'b000, F_H = 3'b001, F_W = 3'b010, F_BU = 3'b100, F_HU = 3'b101;

    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    data_mem_ctrl_if bus0();
    data_mem_ctrl_if bus1();

    data_mem_ctrl #(.DEPTH_WORDS(64), .WAIT_CYCLES(0)) u_dut0 (.clk(clk), .rst(rst), .bus(bus0.slave));
    data_mem_ctrl #(.DEPTH_WORDS(64), .WAIT_CYCLES(3)) u_dut1 (.clk(clk), .rst(rst), .bus(bus1.slave));

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic drive_req(input int sel, input logic wr, input logic [2:0] f3,
                             input logic [31:0] addr, input logic [31:0] wd);
        if (sel == 0) begin
            bus0.req_valid = 1'b1; bus0.req_write = wr; bus0.req_func3 = f3;
            bus0.req_addr  = addr; bus0.req_wdata = wd;
        end else begin
            bus1.req_valid = 1'b1; bus1.req_write = wr; bus1.req_func3 = f3;
            bus1.req_addr  = addr; bus1.req_wdata = wd;
        end
        @(posedge clk);
        #1;
        // Scramble inputs after the handshake to prove they were captured.
        if (sel == 0) begin
            bus0.req_valid = 1'b0; bus0.req_write = ~wr; bus0.req_func3 = 3'b111;
            bus0.req_addr  = 32'hFFFF_FFFF; bus0.req_wdata = ~wd;
        end else begin
            bus1.req_valid = 1'b0; bus1.req_write = ~wr; bus1.req_func3 = 3'b111;
            bus1.req_addr  = 32'hFFFF_FFFF; bus1.req_wdata = ~wd;
        end
    endtask

    task automatic xact(input int sel, input logic wr, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wd, input int exp_lat, input logic exp_err,
                        input logic [31:0] exp_rd, input bit chk_rd, input string tag);
        int   lat;
        logic rdy_low;
        logic [31:0] rd;
        logic er;
        lat = 0; rdy_low = 1'b1; rd = 32'd0; er = 1'b0;
        drive_req(sel, wr, f3, addr, wd);
        for (int n = 1; n <= 20; n++) begin
            @(negedge clk);
            if ((sel == 0) ? bus0.req_ready : bus1.req_ready) rdy_low = 1'b0;
            if ((sel == 0) ? bus0.rsp_valid : bus1.rsp_valid) begin
                lat = n;
                rd  = (sel == 0) ? bus0.rsp_rdata : bus1.rsp_rdata;
                er  = (sel == 0) ? bus0.rsp_err   : bus1.rsp_err;
                break;
            end
        end
        check_val({tag, ".lat"}, 32'(lat), 32'(exp_lat));
        check_val({tag, ".err"}, {31'd0, er}, {31'd0, exp_err});
        if (chk_rd) check_val({tag, ".rdata"}, rd, exp_rd);
        check_val({tag, ".ready_low"}, {31'd0, rdy_low}, 32'd1);
        @(posedge clk);
        #1;
        check_val({tag, ".ready_back"}, {31'd0, (sel == 0) ? bus0.req_ready : bus1.req_ready}, 32'd1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check_val({tag, ".ready"}, {31'd0, bus0.req_ready}, 32'd1);
        check_val({tag, ".valid"}, {31'd0, bus0.rsp_valid}, 32'd0);
        check_val({tag, ".rdata"}, bus0.rsp_rdata, 32'd0);
        check_val({tag, ".err"},   {31'd0, bus0.rsp_err},   32'd0);
    endtask

    task automatic reset_mid_op(input string tag);
        logic seen;
        seen = 1'b0;
        rst  = 1'b1;
        #1;
        check_reset_outputs(tag);
        repeat (2) begin @(negedge clk); if (bus0.rsp_valid) seen = 1'b1; end
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (4) begin @(negedge clk); if (bus0.rsp_valid) seen = 1'b1; end
        check_val({tag, ".no_rsp"}, {31'd0, seen}, 32'd0);
        @(posedge clk); #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus0.req_valid = 1'b0; bus0.req_write = 1'b0; bus0.req_func3 = 3'd0;
        bus0.req_addr  = 32'd0; bus0.req_wdata = 32'd0;
        bus1.req_valid = 1'b0; bus1.req_write = 1'b0; bus1.req_func3 = 3'd0;
        bus1.req_addr  = 32'd0; bus1.req_wdata = 32'd0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        check_val("reset.ready1", {31'd0, bus1.req_ready}, 32'd1);
        rst = 1'b0;
        @(posedge clk); #1;

        // Aligned word round trip
        xact(0, 1'b1, F_W, 32'h10, 32'hDEADBEEF, 2, 1'b0, 32'd0, 1'b0, "sw10");
        xact(0, 1'b0, F_W, 32'h10, 32'd0, 2, 1'b0, 32'hDEADBEEF, 1'b1, "lw10");

        // Byte store into a known word, then signed/unsigned reads
        xact(0, 1'b1, F_W,  32'h20, 32'h44332211, 2, 1'b0, 32'd0, 1'b0, "sw20");
        xact(0, 1'b1, F_B,  32'h21, 32'h00000080, 2, 1'b0, 32'd0, 1'b0, "sb21");
        xact(0, 1'b0, F_B,  32'h21, 32'd0, 2, 1'b0, 32'hFFFFFF80, 1'b1, "lb21");
        xact(0, 1'b0, F_BU, 32'h21, 32'd0, 2, 1'b0, 32'h00000080, 1'b1, "lbu21");
        xact(0, 1'b0, F_HU, 32'h20, 32'd0, 2, 1'b0, 32'h00008011, 1'b1, "lhu20");
        xact(0, 1'b0, F_H,  32'h22, 32'd0, 2, 1'b0, 32'h00004433, 1'b1, "lh22");
        xact(0, 1'b0, F_W,  32'h20, 32'd0, 2, 1'b0, 32'h44338011, 1'b1, "lw20");

        // Wait states
        xact(1, 1'b1, F_H,  32'h02, 32'h00008001, 5, 1'b0, 32'd0, 1'b0, "w3.sh02");
        xact(1, 1'b0, F_H,  32'h02, 32'd0, 5, 1'b0, 32'hFFFF8001, 1'b1, "w3.lh02");
        xact(1, 1'b0, F_HU, 32'h02, 32'd0, 5, 1'b0, 32'h00008001, 1'b1, "w3.lhu02");

        // Cross-word access
        xact(0, 1'b1, F_W, 32'h0C, 32'hAAAAAAAA, 2, 1'b0, 32'd0, 1'b0, "sw0c");
        xact(0, 1'b1, F_W, 32'h10, 32'hBBBBBBBB, 2, 1'b0, 32'd0, 1'b0, "sw10b");
`ifdef MISALIGN_SPLIT_EN
        xact(0, 1'b1, F_W, 32'h0D, 32'h11223344, 3, 1'b0, 32'd0, 1'b0, "sw0d");
        xact(0, 1'b0, F_W, 32'h0D, 32'd0, 3, 1'b0, 32'h11223344, 1'b1, "lw0d");
        xact(0, 1'b0, F_H, 32'h0F, 32'd0, 3, 1'b0, 32'h00001122, 1'b1, "lh0f");
        xact(0, 1'b0, F_W, 32'h0C, 32'd0, 2, 1'b0, 32'h223344AA, 1'b1, "lw0c");
        xact(0, 1'b0, F_W, 32'h10, 32'd0, 2, 1'b0, 32'hBBBBBB11, 1'b1, "lw10c");
`else
        xact(0, 1'b1, F_W, 32'h0D, 32'h11223344, 2, 1'b1, 32'd0, 1'b1, "sw0d");
        xact(0, 1'b0, F_W, 32'h0D, 32'd0, 2, 1'b1, 32'd0, 1'b1, "lw0d");
        xact(0, 1'b0, F_H, 32'h0F, 32'd0, 2, 1'b1, 32'd0, 1'b1, "lh0f");
        xact(0, 1'b0, F_W, 32'h0C, 32'd0, 2, 1'b0, 32'hAAAAAAAA, 1'b1, "lw0c");
        xact(0, 1'b0, F_W, 32'h10, 32'd0, 2, 1'b0, 32'hBBBBBBBB, 1'b1, "lw10c");
`endif

        // Range edge and encoding errors
        xact(0, 1'b1, F_W,  32'hFC,  32'hCAFEF00D, 2, 1'b0, 32'd0, 1'b0, "swfc");
        xact(0, 1'b0, F_W,  32'hFC,  32'd0, 2, 1'b0, 32'hCAFEF00D, 1'b1, "lwfc");
        xact(0, 1'b0, F_W,  32'h100, 32'd0, 2, 1'b1, 32'd0, 1'b1, "lw100");
        xact(0, 1'b0, F_H,  32'hFF,  32'd0, 2, 1'b1, 32'd0, 1'b1, "lhff");
        xact(0, 1'b1, F_W,  32'h08,  32'h12345678, 2, 1'b0, 32'd0, 1'b0, "sw08");
        xact(0, 1'b1, F_BU, 32'h08,  32'h000000FF, 2, 1'b1, 32'd0, 1'b1, "sbu08");
        xact(0, 1'b0, 3'b011, 32'h08, 32'd0, 2, 1'b1, 32'd0, 1'b1, "f3_011");
        xact(0, 1'b0, F_W,  32'h08,  32'd0, 2, 1'b0, 32'h12345678, 1'b1, "lw08");

        // Reset during an access
`ifdef MISALIGN_SPLIT_EN
        xact(0, 1'b1, F_W, 32'h30, 32'h00000000, 2, 1'b0, 32'd0, 1'b0, "sw30");
        xact(0, 1'b1, F_W, 32'h34, 32'h55555555, 2, 1'b0, 32'd0, 1'b0, "sw34");
        xact(0, 1'b0, F_W, 32'h34, 32'd0, 2, 1'b0, 32'h55555555, 1'b1, "lw34");
        drive_req(0, 1'b1, F_W, 32'h33, 32'h99887766);
        @(posedge clk); #1;
        reset_mid_op("rst_acc1");
        xact(0, 1'b0, F_W, 32'h30, 32'd0, 2, 1'b0, 32'h66000000, 1'b1, "lw30r");
        xact(0, 1'b0, F_W, 32'h34, 32'd0, 2, 1'b0, 32'h55555555, 1'b1, "lw34r");
`else
        xact(0, 1'b1, F_W, 32'h30, 32'h12121212, 2, 1'b0, 32'd0, 1'b0, "sw30");
        xact(0, 1'b0, F_W, 32'h30, 32'd0, 2, 1'b0, 32'h12121212, 1'b1, "lw30");
        drive_req(0, 1'b1, F_W, 32'h30, 32'h77777777);
        reset_mid_op("rst_acc0");
        xact(0, 1'b0, F_W, 32'h30, 32'd0, 2, 1'b0, 32'h12121212, 1'b1, "lw30r");
`endif

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
